// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift-register family (transmit and
// receive sides).
//   state_t        : two-state shifter FSM encoding (IDLE, SHIFT)
//   IDLE_LEVEL_DEF : default level of the serial line between words
//   cnt_width()    : width of a bit counter that can hold DATA_W-1
package shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // $clog2(data_w) always holds data_w-1; clamp to 1 bit so a degenerate
  // width can never produce a zero-width counter.
  function automatic int cnt_width(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in, serial-out transmitter. A DATA_W-bit word is accepted over a
// valid/ready handshake and shifted out on sdo, one bit per clock. Words
// offered back-to-back are sent without a gap between them.
//
// Ports
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_data   : parallel word, sampled only when in_valid && in_ready
//   in_valid  : upstream offers a word
//   in_ready  : a word is accepted this cycle (idle, or on the last bit)
//   sdo       : serial data, registered; IDLE_LEVEL between words
//   sframe    : registered, high while sdo carries a data bit
//   sdo_last  : registered, high with the final bit of each word
//   busy      : high while the FSM is in SHIFT
module shift_reg_piso_tx
  import shift_reg_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdo,
  output logic              sframe,
  output logic              sdo_last,
  output logic              busy
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic              sdo_nx, sframe_nx, last_nx;
  logic              accept;

  // Move every bit one place toward the head; the vacated tail fills with 0.
  function automatic logic [DATA_W-1:0] shift_toward_head(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) return {v[DATA_W-2:0], 1'b0};
    else           return {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  // Ready is decoded from registered state only, so it never loops back
  // through in_valid.
  assign in_ready = (state == IDLE) || ((state == SHIFT) && (cnt == '0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT);

  // Next-state: state, counter and shift register.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          cnt_nx   = CNT_LOAD;
          sreg_nx  = in_data;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Reloading on the last bit keeps the stream gapless.
          if (accept) begin
            cnt_nx  = CNT_LOAD;
            sreg_nx = in_data;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          sreg_nx = shift_toward_head(sreg);
          cnt_nx  = cnt - CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so sdo,
  // sframe and sdo_last come straight from flops.
  always_comb begin
    sdo_nx    = IDLE_LEVEL;
    sframe_nx = 1'b0;
    last_nx   = 1'b0;
    if (state_nx == SHIFT) begin
      sdo_nx    = head_bit(sreg_nx);
      sframe_nx = 1'b1;
      last_nx   = (cnt_nx == '0);
    end
  end

  // State register. Reset drops any partially sent word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      sdo      <= IDLE_LEVEL;
      sframe   <= 1'b0;
      sdo_last <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sreg     <= sreg_nx;
      sdo      <= sdo_nx;
      sframe   <= sframe_nx;
      sdo_last <= last_nx;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Bench for shift_reg_piso_tx: three instances (8-bit MSB-first, 8-bit
// LSB-first, 4-bit MSB-first). Each accepted word pushes its expected bit
// sequence onto a per-instance queue; every cycle the head of the queue is
// compared against sdo/sframe/sdo_last/busy/in_ready.
module tb_shift_reg_piso_tx;

  logic       clk;
  logic       reset_n;
  logic [7:0] din8m, din8l;
  logic [3:0] din4;
  logic       vin [3];
  logic       rdy [3];
  logic       sdo_w [3];
  logic       sfr [3];
  logic       lst [3];
  logic       bsy [3];

  int vectors;
  int miscompares;

  // Each entry is {last, bit} for one serial cycle.
  logic [1:0] q [3][$];
  logic       acc [3];

  shift_reg_piso_tx #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_8m (
    .clk(clk), .reset_n(reset_n), .in_data(din8m), .in_valid(vin[0]),
    .in_ready(rdy[0]), .sdo(sdo_w[0]), .sframe(sfr[0]), .sdo_last(lst[0]),
    .busy(bsy[0]));

  shift_reg_piso_tx #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_8l (
    .clk(clk), .reset_n(reset_n), .in_data(din8l), .in_valid(vin[1]),
    .in_ready(rdy[1]), .sdo(sdo_w[1]), .sframe(sfr[1]), .sdo_last(lst[1]),
    .busy(bsy[1]));

  shift_reg_piso_tx #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_4 (
    .clk(clk), .reset_n(reset_n), .in_data(din4), .in_valid(vin[2]),
    .in_ready(rdy[2]), .sdo(sdo_w[2]), .sframe(sfr[2]), .sdo_last(lst[2]),
    .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic int width_of(input int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [7:0] word_of(input int i);
    case (i)
      0:       return din8m;
      1:       return din8l;
      default: return {4'h0, din4};
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [7:0] w);
    int wd;
    int idx;
    wd = width_of(i);
    for (int b = 0; b < wd; b++) begin
      idx = msb_of(i) ? (wd - 1 - b) : b;
      q[i].push_back({(b == wd - 1), w[idx]});
    end
  endtask

  task automatic check_outputs();
    logic exp_fr, exp_bit, exp_last;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0) begin
        exp_fr   = 1'b1;
        exp_bit  = q[i][0][0];
        exp_last = q[i][0][1];
      end else begin
        exp_fr   = 1'b0;
        exp_bit  = 1'b0;
        exp_last = 1'b0;
      end
      check($sformatf("dut%0d sframe", i),   sfr[i],   exp_fr);
      check($sformatf("dut%0d sdo", i),      sdo_w[i], exp_bit);
      check($sformatf("dut%0d sdo_last", i), lst[i],   exp_last);
      check($sformatf("dut%0d busy", i),     bsy[i],   exp_fr);
      check($sformatf("dut%0d in_ready", i), rdy[i],   !exp_fr || exp_last);
    end
  endtask

  // One clock: decide acceptance from the bench's own view of ready,
  // retire the bit on the line, queue any accepted word, then check.
  task automatic cycle();
    logic rdy_exp;
    for (int i = 0; i < 3; i++) begin
      rdy_exp = (q[i].size() == 0) || q[i][0][1];
      acc[i]  = vin[i] && rdy_exp;
      if (q[i].size() > 0) void'(q[i].pop_front());
      if (acc[i]) push_word(i, word_of(i));
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_acc(input int i);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc[i] && n < 40);
    if (!acc[i]) begin
      miscompares++;
      $error("FAIL dut%0d accept timeout observed=none expected=handshake", i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    din8m = 8'h00; din8l = 8'h00; din4 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      acc[i] = 1'b0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    idle(2);

    // Single word 0xA5, MSB first.
    din8m = 8'hA5; vin[0] = 1'b1;
    wait_acc(0);
    vin[0] = 1'b0;
    idle(10);

    // Back-to-back 0xA5, 0x3C with valid held high.
    din8m = 8'hA5; vin[0] = 1'b1;
    wait_acc(0);
    din8m = 8'h3C;
    wait_acc(0);
    vin[0] = 1'b0;
    idle(10);

    // LSB-first 0x01 and 4-bit 0xC together, then LSB-first 0x80.
    din8l = 8'h01; din4 = 4'hC; vin[1] = 1'b1; vin[2] = 1'b1;
    cycle();
    vin[1] = 1'b0; vin[2] = 1'b0;
    idle(9);
    din8l = 8'h80; vin[1] = 1'b1;
    wait_acc(1);
    vin[1] = 1'b0;
    idle(9);

    // Word changes mid-shift with valid high: first word stays 0xA5,
    // 0x00 is only taken on the last-bit handshake.
    din8m = 8'hA5; vin[0] = 1'b1;
    wait_acc(0);
    idle(3);
    din8m = 8'h00;
    wait_acc(0);
    vin[0] = 1'b0;
    idle(10);

    // Reset after 3 bits of 0xFF must clear outputs without a clock edge.
    din8m = 8'hFF; vin[0] = 1'b1;
    wait_acc(0);
    vin[0] = 1'b0;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check("reset async sdo",      sdo_w[0], 1'b0);
    check("reset async sframe",   sfr[0],   1'b0);
    check("reset async sdo_last", lst[0],   1'b0);
    check("reset async busy",     bsy[0],   1'b0);
    check("reset async in_ready", rdy[0],   1'b1);
    for (int i = 0; i < 3; i++) q[i].delete();
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    idle(2);
    din8m = 8'h0F; vin[0] = 1'b1;
    wait_acc(0);
    vin[0] = 1'b0;
    idle(10);

    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d queue drained", i), (q[i].size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
